pipeline_fetch_stage: RTL and testbench

//  Instruction-fetch stage and IF/ID pipeline register that produces inst_out, pc_out and pc_incr4_out for the decode stage.

---
 rtl/pipeline_fetch_stage.sv | 153 +++++++++++++++
 tb/tb_pipeline_fetch_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_fetch_stage.sv
// Instruction-fetch stage with IF/ID register: owns the PC, runs a one-outstanding
// req/gnt/rvalid fetch, and honours stall, flush and EX-stage PC redirects.
module pipeline_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_incr4_out,
  output logic        inst_valid,
  output logic        fetch_busy,
  output logic [1:0]  fetch_state_dbg
);

  // Handshake: a request transfers on a cycle where imem_req && imem_gnt; its data
  // returns on a later cycle with imem_rvalid, and only one request is ever outstanding.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        deliver;
  logic [31:0] deliver_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      drop_q   <= 1'b0;
      skid_q   <= 32'd0;
      inst_q   <= NOP_INST;
      pc_out_q <= 32'd0;
      pc4_q    <= 32'd0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      drop_q   <= drop_d;
      skid_q   <= skid_d;
      inst_q   <= inst_d;
      pc_out_q <= pc_out_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    skid_d       = skid_q;
    deliver      = 1'b0;
    deliver_data = skid_q;
    case (state_q)
      ST_FETCH: begin
        // A request accepted in the same cycle as a redirect fetched the stale PC.
        if (imem_gnt) begin
          state_d = ST_WAIT;
          drop_d  = pc_src;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          if (pc_src || drop_q) begin
            state_d = ST_FETCH;
            drop_d  = 1'b0;
          end else if (!stall) begin
            deliver      = 1'b1;
            deliver_data = imem_rdata;
            state_d      = ST_FETCH;
          end else begin
            skid_d  = imem_rdata;
            state_d = ST_HOLD;
          end
        end else if (pc_src) begin
          drop_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (pc_src) begin
          state_d = ST_FETCH;
        end else if (!stall) begin
          deliver = 1'b1;
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_FETCH;
        drop_d  = 1'b0;
      end
    endcase
    if (deliver) begin
      pc_d = pc_q + 32'd4;
    end
    if (pc_src) begin
      pc_d = pc_target & ~32'd3;
    end
  end

  always_comb begin
    imem_req        = (state_q == ST_FETCH) && !rst;
    imem_addr       = pc_q;
    fetch_busy      = !deliver;
    fetch_state_dbg = state_q;
    inst_d          = NOP_INST;
    pc_out_d        = 32'd0;
    pc4_d           = 32'd0;
    valid_d         = 1'b0;
    if (flush) begin
      inst_d   = NOP_INST;
      pc_out_d = 32'd0;
      pc4_d    = 32'd0;
      valid_d  = 1'b0;
    end else if (stall) begin
      inst_d   = inst_q;
      pc_out_d = pc_out_q;
      pc4_d    = pc4_q;
      valid_d  = valid_q;
    end else if (deliver) begin
      inst_d   = deliver_data;
      pc_out_d = pc_q;
      pc4_d    = pc_q + 32'd4;
      valid_d  = 1'b1;
    end
  end

  assign inst_out     = inst_q;
  assign pc_out       = pc_out_q;
  assign pc_incr4_out = pc4_q;
  assign inst_valid   = valid_q;

endmodule

// File: tb/tb_pipeline_fetch_stage.sv
// Directed bench for pipeline_fetch_stage: sequential fetch, stall/skid, redirects,
// flush, PC wrap at the top of memory and asynchronous reset in the middle of a fetch.
module tb_pipeline_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst, stall, flush, pc_src;
  logic [31:0] pc_target;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] inst_out, pc_out, pc_incr4_out;
  logic        inst_valid, fetch_busy;
  logic [1:0]  fetch_state_dbg;

  logic        h_rst, h_gnt, h_rvalid, h_zero;
  logic [31:0] h_rdata, h_target;
  logic        h_req, h_valid, h_busy;
  logic [31:0] h_addr, h_inst, h_pc_out, h_pc4;
  logic [1:0]  h_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_fetch_stage u_dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .pc_src(pc_src),
    .pc_target(pc_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_out(inst_out), .pc_out(pc_out), .pc_incr4_out(pc_incr4_out),
    .inst_valid(inst_valid), .fetch_busy(fetch_busy), .fetch_state_dbg(fetch_state_dbg)
  );

  pipeline_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_hi (
    .clk(clk), .rst(h_rst), .stall(h_zero), .flush(h_zero), .pc_src(h_zero),
    .pc_target(h_target), .imem_req(h_req), .imem_addr(h_addr),
    .imem_gnt(h_gnt), .imem_rvalid(h_rvalid), .imem_rdata(h_rdata),
    .inst_out(h_inst), .pc_out(h_pc_out), .pc_incr4_out(h_pc4),
    .inst_valid(h_valid), .fetch_busy(h_busy), .fetch_state_dbg(h_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("comparison %s differs", tag);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // One request at addr with 1-cycle memory; stall must be low, FSM in FETCH.
  task automatic fetch_deliver(input string tag, input logic [31:0] addr, input logic [31:0] word);
    imem_gnt = 1'b1;
    settle();
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    chk({tag, "_addr"}, imem_addr, addr);
    cyc();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    settle();
    chk({tag, "_bubble_valid"}, {31'd0, inst_valid}, 32'd0);
    chk({tag, "_bubble_inst"}, inst_out, NOP);
    chk({tag, "_busy"}, {31'd0, fetch_busy}, 32'd0);
    cyc();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hBAD0_BAD0;
    settle();
    chk({tag, "_inst"}, inst_out, word);
    chk({tag, "_pc"}, pc_out, addr);
    chk({tag, "_pc4"}, pc_incr4_out, addr + 32'd4);
    chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
  endtask

  // driver / directed steps
  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; pc_src = 1'b0; pc_target = 32'd0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    h_rst = 1'b1; h_gnt = 1'b0; h_rvalid = 1'b0; h_rdata = 32'd0; h_zero = 1'b0;
    h_target = 32'd0;
    cyc(); cyc();

    // reset state
    chk("rst_inst", inst_out, NOP);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_pc4", pc_incr4_out, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_state", {30'd0, fetch_state_dbg}, 32'd0);
    rst = 1'b0;

    // T1: sequential fetch
    fetch_deliver("t1_a0", 32'h0, 32'h0010_0093);
    fetch_deliver("t1_a1", 32'h4, 32'h0020_0113);
    fetch_deliver("t1_a2", 32'h8, 32'h0030_0193);

    // T2: stall through prefetch and skid
    stall = 1'b1; imem_gnt = 1'b1;
    settle();
    chk("t2_prefetch_req", {31'd0, imem_req}, 32'd1);
    chk("t2_prefetch_addr", imem_addr, 32'hC);
    cyc();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    settle();
    chk("t2_hold_inst_w", inst_out, 32'h0030_0193);
    chk("t2_busy_w", {31'd0, fetch_busy}, 32'd1);
    cyc();
    imem_rvalid = 1'b0; imem_rdata = 32'd0;
    settle();
    chk("t2_state_hold", {30'd0, fetch_state_dbg}, 32'd2);
    chk("t2_req_hold", {31'd0, imem_req}, 32'd0);
    chk("t2_busy_h", {31'd0, fetch_busy}, 32'd1);
    cyc(); cyc();
    chk("t2_held_pc", pc_out, 32'h8);
    chk("t2_held_valid", {31'd0, inst_valid}, 32'd1);
    stall = 1'b0;
    settle();
    chk("t2_busy_rel", {31'd0, fetch_busy}, 32'd0);
    cyc();
    chk("t2_inst", inst_out, 32'h0050_0093);
    chk("t2_pc", pc_out, 32'hC);
    chk("t2_pc4", pc_incr4_out, 32'h10);

    // T3: redirect + flush while waiting, late rvalid dropped
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0; pc_src = 1'b1; flush = 1'b1; pc_target = 32'h100;
    cyc();
    pc_src = 1'b0; flush = 1'b0;
    chk("t3_wait_req", {31'd0, imem_req}, 32'd0);
    chk("t3_flush_valid", {31'd0, inst_valid}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    settle();
    chk("t3_drop_busy", {31'd0, fetch_busy}, 32'd1);
    cyc();
    imem_rvalid = 1'b0;
    chk("t3_drop_valid", {31'd0, inst_valid}, 32'd0);
    chk("t3_drop_inst", inst_out, NOP);
    fetch_deliver("t3_tgt", 32'h100, 32'h1111_1111);

    // T4: misaligned target without grant, then flush alone
    pc_src = 1'b1; pc_target = 32'h203;
    settle();
    chk("t4_old_addr", imem_addr, 32'h104);
    cyc();
    pc_src = 1'b0;
    fetch_deliver("t4_tgt", 32'h200, 32'h2222_2222);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("t4_flush_valid", {31'd0, inst_valid}, 32'd0);
    chk("t4_flush_pc", pc_out, 32'd0);
    chk("t4_flush_addr", imem_addr, 32'h204);
    fetch_deliver("t4_seq", 32'h204, 32'h3333_3333);

    // redirect with grant in the same cycle: stale response discarded
    imem_gnt = 1'b1; pc_src = 1'b1; pc_target = 32'h300;
    cyc();
    imem_gnt = 1'b0; pc_src = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBEEF_0001;
    settle();
    chk("t4_gnt_drop_busy", {31'd0, fetch_busy}, 32'd1);
    cyc();
    imem_rvalid = 1'b0;
    chk("t4_gnt_drop_valid", {31'd0, inst_valid}, 32'd0);
    chk("t4_gnt_drop_addr", imem_addr, 32'h300);

    // redirect while holding a skid entry
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBEEF_0002; stall = 1'b1;
    cyc();
    imem_rvalid = 1'b0; pc_src = 1'b1; pc_target = 32'h400;
    settle();
    chk("t4_hold_redir_busy", {31'd0, fetch_busy}, 32'd1);
    cyc();
    pc_src = 1'b0; stall = 1'b0;
    chk("t4_hold_redir_state", {30'd0, fetch_state_dbg}, 32'd0);
    chk("t4_hold_redir_addr", imem_addr, 32'h400);

    // redirect coinciding with rvalid
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBEEF_0003;
    pc_src = 1'b1; pc_target = 32'h500;
    settle();
    chk("t4_rv_redir_busy", {31'd0, fetch_busy}, 32'd1);
    cyc();
    imem_rvalid = 1'b0; pc_src = 1'b0;
    chk("t4_rv_redir_valid", {31'd0, inst_valid}, 32'd0);
    fetch_deliver("t4_rv_tgt", 32'h500, 32'h5555_5555);

    // T6: async reset mid-WAIT with IF/ID held valid by stall
    stall = 1'b1; imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0;
    chk("t6_pre_pc", pc_out, 32'h500);
    chk("t6_pre_state", {30'd0, fetch_state_dbg}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_valid", {31'd0, inst_valid}, 32'd0);
    chk("t6_async_pc", pc_out, 32'd0);
    chk("t6_async_inst", inst_out, NOP);
    chk("t6_async_req", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hBEEF_0004; stall = 1'b0;
    cyc();
    chk("t6_rst_valid", {31'd0, inst_valid}, 32'd0);
    rst = 1'b0; imem_rvalid = 1'b0;
    settle();
    chk("t6_post_state", {30'd0, fetch_state_dbg}, 32'd0);
    fetch_deliver("t6_post", 32'h0, 32'h6666_6666);

    // T5: RESET_PC at the top of the address space
    chk("t5_rst_pc", h_pc_out, 32'd0);
    chk("t5_rst_req", {31'd0, h_req}, 32'd0);
    h_rst = 1'b0; h_gnt = 1'b1;
    settle();
    chk("t5_addr", h_addr, 32'hFFFF_FFFC);
    cyc();
    h_gnt = 1'b0; h_rvalid = 1'b1; h_rdata = 32'h7777_7777;
    settle();
    chk("t5_busy", {31'd0, h_busy}, 32'd0);
    cyc();
    h_rvalid = 1'b0;
    settle();
    chk("t5_pc", h_pc_out, 32'hFFFF_FFFC);
    chk("t5_pc4", h_pc4, 32'd0);
    chk("t5_inst", h_inst, 32'h7777_7777);
    chk("t5_valid", {31'd0, h_valid}, 32'd1);
    chk("t5_next_addr", h_addr, 32'd0);
    chk("t5_next_req", {31'd0, h_req}, 32'd1);
    chk("t5_state", {30'd0, h_dbg}, 32'd0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
